// File: rtl/long_press_detect.sv
// long_press_detect: asserts `out` once `in` has been sampled high on
// PRESS_CYCLES consecutive rising clock edges. `out` holds while the press
// continues and clears on the first edge that samples a release.
//
// Optional input synchronizer: define LONG_PRESS_SYNC_EN to pass `in`
// through a 2-flop synchronizer. Every latency then grows by two clocks.
//
// `resetn` is asynchronous and active-high despite its name. It clears the
// counter, the output flag and the synchronizer flops.
`timescale 1ns/1ps

module long_press_detect #(
  parameter int CLK_PERIOD_ns  = 20,
  parameter int PRESS_TIMER_ns = 500000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic in,
  output logic out
);

  // Hold time expressed in clock edges. A timer shorter than one clock still
  // needs at least one high sample.
  localparam int PRESS_RAW    = PRESS_TIMER_ns / CLK_PERIOD_ns;
  localparam int PRESS_CYCLES = (PRESS_RAW < 1) ? 1 : PRESS_RAW;
  localparam int CNT_W_RAW    = $clog2(PRESS_CYCLES + 1);
  localparam int CNT_W        = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESS_CYCLES);

  logic             in_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             out_nxt;

`ifdef LONG_PRESS_SYNC_EN
  logic sync0;
  logic sync1;

  // Two-flop synchronizer for an input that is asynchronous to clk.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= in;
      sync1 <= sync0;
    end
  end

  assign in_s = sync1;
`else
  // The caller supplies an input that is already synchronous to clk.
  assign in_s = in;
`endif

  // Next counter and flag: a low sample restarts the count. A high sample
  // advances the count until it saturates at PRESS_CYCLES, which raises the flag.
  always_comb begin
    cnt_nxt = cnt;
    out_nxt = out;
    if (!in_s) begin
      cnt_nxt = '0;
      out_nxt = 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = CNT_MAX;
      out_nxt = 1'b1;
    end else if (cnt < CNT_LAST) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Counter and flag registers. Reset clears them immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt <= '0;
      out <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      out <= out_nxt;
    end
  end

endmodule

// File: tb/tb_long_press_detect.sv
// Directed bench for long_press_detect (CLK 20 ns, timer 500 ns, 25 edges).
// The stimulus process pushes the expected `out` for each clock edge and for
// each asynchronous reset pulse. A monitor process pops those values and
// compares them against the DUT.
`timescale 1ns/1ps

module tb_long_press_detect;

  localparam int CLK_NS = 20;
  localparam int TMR_NS = 500;
  localparam int PC     = 25;
`ifdef LONG_PRESS_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic in = 1'b0;
  logic out;

  long_press_detect #(
    .CLK_PERIOD_ns (CLK_NS),
    .PRESS_TIMER_ns(TMR_NS)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .in    (in),
    .out   (out)
  );

  always #(CLK_NS/2) clk = ~clk;

  logic exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_now;

  // Expected-value state: the count of consecutive high samples and the
  // bench's own synchronizer stages.
  int   run = 0;
  logic d0 = 1'b0;
  logic d1 = 1'b0;
  logic cur_in = 1'b0;

  // Monitor: pops one expectation per falling edge, or on an async-reset check.
  always begin
    @(negedge clk or chk_now);
    if (exp_q.size() > 0) begin
      logic e;
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e) begin
        n_bad++;
        $display("FAIL out @%0t: got %b expected %b", $time, out, e);
      end
    end
  end

  // One clock: account for the edge that sampled cur_in, then drive v.
  task automatic cyc(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      logic s;
      @(posedge clk);
      if (resetn) begin
        run = 0; d0 = 1'b0; d1 = 1'b0;
        exp_q.push_back(1'b0);
      end else begin
        s  = SYNC ? d1 : cur_in;
        d1 = d0;
        d0 = cur_in;
        if (!s) run = 0;
        else if (run < PC) run = run + 1;
        exp_q.push_back(run >= PC);
      end
      #2;
      in = v;
      cur_in = v;
    end
  endtask

  // Pulse reset between edges, after the falling-edge check, and verify
  // that out drops without a clock edge.
  task automatic pulse_rst();
    @(negedge clk);
    #2;
    resetn = 1'b1;
    run = 0; d0 = 1'b0; d1 = 1'b0;
    #1;
    exp_q.push_back(1'b0);
    -> chk_now;
    #2;
    resetn = 1'b0;
  endtask

  initial begin
    // Reset held across a few edges, then released.
    cyc(1'b0, 3);
    resetn = 1'b0;
    cyc(1'b0, 3);
    // Basic long press: out rises on the 25th high edge and stays high.
    cyc(1'b1, 35);
    // Release: out clears on the next edge.
    cyc(1'b0, 3);
    // Glitch mid-press restarts the count.
    cyc(1'b1, 10);
    cyc(1'b0, 1);
    cyc(1'b1, 30);
    // Short press (24 edges) never asserts; re-press asserts on the 25th edge.
    cyc(1'b0, 2);
    cyc(1'b1, 24);
    cyc(1'b0, 2);
    cyc(1'b1, 26);
    // Async reset during a long press (out=1): out drops at once, then the
    // count restarts while in stays high.
    cyc(1'b1, 3);
    pulse_rst();
    cyc(1'b1, 30);
    // Async reset during a short press.
    cyc(1'b0, 2);
    cyc(1'b1, 10);
    pulse_rst();
    cyc(1'b1, 28);
    // Idle tail.
    cyc(1'b0, 5);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/long_press_detect.md
Name: long_press_detect

Overview:
- Long-press detector for a single push-button / level input.
- Asserts `out` once `in` has been continuously high for `PRESS_TIMER_ns`, derived from the clock period.
- `out` stays high while the press continues and drops on release.
- Sits between the button input conditioning and the control FSM that consumes "long press" events.

Parameters:
- CLK_PERIOD_ns, 20: clock period in ns, integer, >0.
- PRESS_TIMER_ns, 500000000: required hold time in ns, integer, >0.
- Derived localparam PRESS_CYCLES = PRESS_TIMER_ns / CLK_PERIOD_ns, truncating division; forced to 1 if the result is 0.
- Derived localparam CNT_W = $clog2(PRESS_CYCLES+1), minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  one clock; reset is asynchronous and active-high. Asserted when 1 despite the name; clears all state immediately.
- in  input  1  button level, 1 = pressed.
- out  input→output  1  long-press flag, registered, 1 while the press has lasted ≥ PRESS_CYCLES clocks.

Behaviour:
- State: counter `cnt` [CNT_W-1:0] and register `out`. No other outputs.
- Reset (resetn=1, async): cnt=0, out=0. Holds while asserted regardless of `in` or clk.
- Each rising clk edge, with `in_s` = the sampled input (`in` directly, or the synchronized version; see Optional Feature):
  - in_s=0: cnt<=0, out<=0. Release clears immediately, one edge.
  - in_s=1 and cnt < PRESS_CYCLES-1: cnt<=cnt+1, out unchanged (0).
  - in_s=1 and cnt == PRESS_CYCLES-1: cnt<=PRESS_CYCLES (saturate), out<=1.
  - in_s=1 and cnt == PRESS_CYCLES: hold; cnt saturated, out stays 1, no wrap.
- Latency: out rises on the PRESS_CYCLES-th consecutive rising edge at which in_s=1. Example: 20 ns clock, 500 ns timer gives 25 edges, so out rises 481–500 ns after `in` rises, depending on phase.
- PRESS_CYCLES=1: out rises on the first edge sampling in_s=1.
- Glitches and partial presses: any single low sample restarts the count from 0. No accumulation across presses.
- Reset mid-press: count restarts from 0 after reset deasserts, even if `in` is still high. out stays 0 until PRESS_CYCLES further high samples.
- Reset mid-long-press: out drops asynchronously at reset assertion.
- Input changes between edges are ignored; only edge samples matter.
- Timing of `in` relative to clk is not constrained when the synchronizer is compiled out. The caller supplies a synchronous input in that case.

Optional Feature:
- Macro: LONG_PRESS_SYNC_EN.
- Defined:
  - `in` passes through a 2-flop synchronizer (sync0, sync1), both reset to 0 asynchronously.
  - in_s = sync1.
  - All latencies grow by 2 clocks: out rises PRESS_CYCLES+2 edges after the first edge sampling `in`=1, and falls 3 edges after release instead of 1.
- Not defined: in_s = `in`, latencies exactly as in Behaviour.

Test Plan (CLK_PERIOD_ns=20, PRESS_TIMER_ns=500, PRESS_CYCLES=25, macro undefined unless stated):
- Async reset: pulse resetn=1 between edges while in=1 → out=0 and cnt=0 immediately. After deassert, out still 0 for 24 edges.
- Basic long press: in 0→1 at t0 and held → out rises on the 25th edge after t0, i.e. (t0, t0+500 ns]. Expect ~480–500 ns for mid-period stimulus. out stays 1 while held.
- Release: while out=1, drop in → out=0 on the next rising edge.
- Re-press after short gap: in low for 30 ns (≥1 edge sampled low), then high → out rises again after 25 more high edges, not earlier.
- Short press: in high for 24 edges then low → out never asserts. Re-press high for 25 edges → out asserts exactly on the 25th.
- Sync build (LONG_PRESS_SYNC_EN): same press as the basic case → out rises on the 27th edge. Release → out falls on the 3rd edge.
